cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// ============================================================================
// cpu_sequencer : fetch/decode/execute control FSM for a 4-bit accumulator CPU
// Revision 1.0
// ============================================================================
`default_nettype none

module cpu_sequencer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] instr_i,
  input  logic       mem_ack_i,
  input  logic       carry_i,
  input  logic       zero_i,
  input  logic       inp_valid_i,
  input  logic       out_ready_i,
  output logic [3:0] pc_o,
  output logic [7:0] ir_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic [3:0] mem_addr_o,
  output logic       acc_we_o,
  output logic [1:0] acc_sel_o,
  output logic [2:0] alu_op_o,
  output logic       alu_b_mem_o,
  output logic       flags_we_o,
  output logic       inp_ready_o,
  output logic       out_valid_o,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM_RD = 3'd3;
  localparam logic [2:0] S_MEM_WR = 3'd4;
  localparam logic [2:0] S_ALU_RD = 3'd5;
  localparam logic [2:0] S_IO_IN  = 3'd6;
  localparam logic [2:0] S_IO_OUT = 3'd7;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_INP = 4'h3;
  localparam logic [3:0] OP_OUT = 4'h4;
  localparam logic [3:0] OP_BRC = 4'h5;
  localparam logic [3:0] OP_BRZ = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_ADI = 4'h8;
  localparam logic [3:0] OP_LSL = 4'hE;
  localparam logic [3:0] OP_LSR = 4'hF;

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_IMM = 2'd2;
  localparam logic [1:0] SEL_INP = 2'd3;

  logic [2:0] state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [3:0] opcode;
  logic [3:0] operand;

  assign opcode  = ir_q[7:4];
  assign operand = ir_q[3:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      pc_q    <= 4'd0;
      ir_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ack_i) begin
          ir_d    = instr_i;
          pc_d    = pc_q + 4'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LDA:                    state_d = S_MEM_RD;
          OP_STA:                    state_d = S_MEM_WR;
          OP_INP:                    state_d = S_IO_IN;
          OP_OUT:                    state_d = S_IO_OUT;
          4'h9, 4'hA, 4'hB, 4'hC, 4'hD: state_d = S_ALU_RD;
          default:                   state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        // Not-taken branches simply leave the already-incremented pc alone.
        if ((opcode == OP_JMP) ||
            ((opcode == OP_BRC) && carry_i) ||
            ((opcode == OP_BRZ) && zero_i)) begin
          pc_d = operand;
        end
        state_d = S_FETCH;
      end
      S_MEM_RD, S_MEM_WR, S_ALU_RD: begin
        if (mem_ack_i) state_d = S_FETCH;
      end
      S_IO_IN: begin
        if (inp_valid_i) state_d = S_FETCH;
      end
      S_IO_OUT: begin
        if (out_ready_i) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = (state_q == S_FETCH) ? pc_q : operand;
    acc_we_o    = 1'b0;
    acc_sel_o   = SEL_ALU;
    alu_b_mem_o = 1'b0;
    flags_we_o  = 1'b0;
    inp_ready_o = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      S_FETCH: mem_req_o = 1'b1;
      S_EXEC: begin
        case (opcode)
          OP_LDI: begin
            acc_we_o  = 1'b1;
            acc_sel_o = SEL_IMM;
          end
          OP_ADI, OP_LSL, OP_LSR: begin
            acc_we_o   = 1'b1;
            flags_we_o = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM_RD: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          acc_we_o  = 1'b1;
          acc_sel_o = SEL_MEM;
        end
      end
      S_MEM_WR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
      end
      S_ALU_RD: begin
        mem_req_o   = 1'b1;
        alu_b_mem_o = 1'b1;
        if (mem_ack_i) begin
          acc_we_o   = 1'b1;
          flags_we_o = 1'b1;
        end
      end
      S_IO_IN: begin
        inp_ready_o = 1'b1;
        if (inp_valid_i) begin
          acc_we_o  = 1'b1;
          acc_sel_o = SEL_INP;
        end
      end
      S_IO_OUT: out_valid_o = 1'b1;
      default: ;
    endcase
    // Reset silences every strobe even before the state register has settled.
    if (rst_i) begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      acc_we_o    = 1'b0;
      acc_sel_o   = SEL_ALU;
      alu_b_mem_o = 1'b0;
      flags_we_o  = 1'b0;
      inp_ready_o = 1'b0;
      out_valid_o = 1'b0;
    end
  end

  assign pc_o     = pc_q;
  assign ir_o     = ir_q;
  assign alu_op_o = ir_q[6:4];
  assign state_o  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// ============================================================================
// tb_cpu_sequencer : vector table, hand sequences and randomized model checks
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] instr_i = 8'd0;
  logic       mem_ack_i = 1'b0, carry_i = 1'b0, zero_i = 1'b0;
  logic       inp_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [3:0] pc_o, mem_addr_o;
  logic [7:0] ir_o;
  logic       mem_req_o, mem_we_o, acc_we_o, alu_b_mem_o, flags_we_o;
  logic       inp_ready_o, out_valid_o;
  logic [1:0] acc_sel_o;
  logic [2:0] alu_op_o, state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .mem_ack_i(mem_ack_i),
    .carry_i(carry_i), .zero_i(zero_i), .inp_valid_i(inp_valid_i),
    .out_ready_i(out_ready_i), .pc_o(pc_o), .ir_o(ir_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .acc_we_o(acc_we_o),
    .acc_sel_o(acc_sel_o), .alu_op_o(alu_op_o), .alu_b_mem_o(alu_b_mem_o),
    .flags_we_o(flags_we_o), .inp_ready_o(inp_ready_o),
    .out_valid_o(out_valid_o), .state_o(state_o)
  );

  typedef struct {
    logic       rst;
    logic [7:0] instr;
    logic       ack, iv, ordy, cy, zr;
    logic [2:0] st;
    logic [3:0] pc;
    logic       req, we;
    logic [3:0] addr;
    logic       awe;
    logic [1:0] sel;
    logic       flw, ird, ovl, bmem;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, input logic [7:0] instr, input logic ack, input logic iv,
    input logic ordy, input logic cy, input logic zr, input logic [2:0] st,
    input logic [3:0] pc, input logic req, input logic we, input logic [3:0] addr,
    input logic awe, input logic [1:0] sel, input logic flw, input logic ird,
    input logic ovl, input logic bmem);
    vec_t v;
    v.rst = rst; v.instr = instr; v.ack = ack; v.iv = iv; v.ordy = ordy;
    v.cy = cy; v.zr = zr; v.st = st; v.pc = pc; v.req = req; v.we = we;
    v.addr = addr; v.awe = awe; v.sel = sel; v.flw = flw; v.ird = ird;
    v.ovl = ovl; v.bmem = bmem;
    return v;
  endfunction

  function automatic logic [19:0] dut_vec();
    return {state_o, pc_o, mem_req_o, mem_we_o, mem_addr_o, acc_we_o,
            acc_sel_o, flags_we_o, inp_ready_o, out_valid_o, alu_b_mem_o};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: instruction-level rules, tracked one cycle at a time.
  int         m_st;
  logic [3:0] m_pc;
  logic [7:0] m_ir;

  function automatic int route(input logic [3:0] op);
    if (op == 4'h0) return 3;
    if (op == 4'h2) return 4;
    if (op == 4'h3) return 6;
    if (op == 4'h4) return 7;
    if (op >= 4'h9 && op <= 4'hD) return 5;
    return 2;
  endfunction

  function automatic logic handshake();
    if (m_st == 0 || m_st == 3 || m_st == 4 || m_st == 5) return mem_ack_i;
    if (m_st == 6) return inp_valid_i;
    if (m_st == 7) return out_ready_i;
    return 1'b1;
  endfunction

  function automatic logic [19:0] model_vec();
    logic [3:0] op;
    logic hs, req, we, awe, flw, ird, ovl, bmem;
    logic [1:0] sel;
    logic [3:0] addr;
    op   = m_ir[7:4];
    hs   = handshake();
    addr = (m_st == 0) ? m_pc : m_ir[3:0];
    req  = (m_st == 0 || m_st == 3 || m_st == 4 || m_st == 5);
    we   = (m_st == 4);
    ird  = (m_st == 6);
    ovl  = (m_st == 7);
    bmem = (m_st == 5);
    awe  = 1'b0; flw = 1'b0; sel = 2'd0;
    if (m_st == 2 && op == 4'h1) begin awe = 1'b1; sel = 2'd2; end
    if (m_st == 2 && (op == 4'h8 || op == 4'hE || op == 4'hF)) begin awe = 1'b1; flw = 1'b1; end
    if (m_st == 3 && hs) begin awe = 1'b1; sel = 2'd1; end
    if (m_st == 5 && hs) begin awe = 1'b1; flw = 1'b1; end
    if (m_st == 6 && hs) begin awe = 1'b1; sel = 2'd3; end
    if (rst_i) begin
      req = 1'b0; we = 1'b0; awe = 1'b0; sel = 2'd0;
      flw = 1'b0; ird = 1'b0; ovl = 1'b0; bmem = 1'b0;
    end
    return {3'(m_st), m_pc, req, we, addr, awe, sel, flw, ird, ovl, bmem};
  endfunction

  task automatic model_step();
    logic [3:0] op;
    op = m_ir[7:4];
    if (rst_i) begin
      m_st = 0; m_pc = 4'd0; m_ir = 8'd0;
    end else if (handshake()) begin
      case (m_st)
        0: begin m_ir = instr_i; m_pc = m_pc + 4'd1; m_st = 1; end
        1: m_st = route(op);
        2: begin
          if (op == 4'h7 || (op == 4'h5 && carry_i) || (op == 4'h6 && zero_i))
            m_pc = m_ir[3:0];
          m_st = 0;
        end
        default: m_st = 0;
      endcase
    end
  endtask

  initial begin
    // rst instr ack iv or cy zr | st pc req we addr awe sel flw ird ovl bmem
    vecs.push_back(mk(1,8'h00,0,0,0,0,0, 0,4'h0,0,0,4'h0,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h1A,1,0,0,0,0, 0,4'h0,1,0,4'h0,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,0,0,0,0,0, 1,4'h1,0,0,4'hA,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,0,0,0,0,0, 2,4'h1,0,0,4'hA,1,2,0,0,0,0));
    vecs.push_back(mk(0,8'h6C,1,0,0,0,0, 0,4'h1,1,0,4'h1,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,0,0,0,0,0, 1,4'h2,0,0,4'hC,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,0,0,0,0,1, 2,4'h2,0,0,4'hC,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h6C,1,0,0,0,0, 0,4'hC,1,0,4'hC,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,0,0,0,0,0, 1,4'hD,0,0,4'hC,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,0,0,0,1,0, 2,4'hD,0,0,4'hC,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h05,1,0,0,0,0, 0,4'hD,1,0,4'hD,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,0,0,0,0,0, 1,4'hE,0,0,4'h5,0,0,0,0,0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,8'h00,0,1,1,0,0, 3,4'hE,1,0,4'h5,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,1,0,0,0,0, 3,4'hE,1,0,4'h5,1,1,0,0,0,0));
    vecs.push_back(mk(0,8'h9F,1,0,0,0,0, 0,4'hE,1,0,4'hE,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,0,0,0,0,0, 1,4'hF,0,0,4'hF,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,1,0,0,0,0, 5,4'hF,1,0,4'hF,1,0,1,0,0,1));
    vecs.push_back(mk(0,8'h70,1,0,0,0,0, 0,4'hF,1,0,4'hF,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,0,0,0,0,0, 1,4'h0,0,0,4'h0,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,0,0,0,0,0, 2,4'h0,0,0,4'h0,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h30,1,0,0,0,0, 0,4'h0,1,0,4'h0,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,0,0,0,0,0, 1,4'h1,0,0,4'h0,0,0,0,0,0,0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,8'h00,1,0,1,0,0, 6,4'h1,0,0,4'h0,0,0,0,1,0,0));
    vecs.push_back(mk(0,8'h00,0,1,0,0,0, 6,4'h1,0,0,4'h0,1,3,0,1,0,0));
    vecs.push_back(mk(0,8'h40,1,0,0,0,0, 0,4'h1,1,0,4'h1,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,0,0,0,0,0, 1,4'h2,0,0,4'h0,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,0,0,1,0,0, 7,4'h2,0,0,4'h0,0,0,0,0,1,0));
    vecs.push_back(mk(0,8'h23,1,0,0,0,0, 0,4'h2,1,0,4'h2,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,0,0,0,0,0, 1,4'h3,0,0,4'h3,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,0,0,0,0,0, 4,4'h3,1,1,4'h3,0,0,0,0,0,0));
    vecs.push_back(mk(1,8'h00,0,0,0,0,0, 4,4'h3,0,0,4'h3,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'hE0,1,0,0,0,0, 0,4'h0,1,0,4'h0,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,0,0,0,0,0, 1,4'h1,0,0,4'h0,0,0,0,0,0,0));
    vecs.push_back(mk(0,8'h00,0,0,0,0,0, 2,4'h1,0,0,4'h0,1,0,1,0,0,0));
    vecs.push_back(mk(0,8'h00,0,1,1,0,0, 0,4'h1,1,0,4'h1,0,0,0,0,0,0));

    rst_i = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      #1;
      rst_i = vecs[i].rst; instr_i = vecs[i].instr; mem_ack_i = vecs[i].ack;
      inp_valid_i = vecs[i].iv; out_ready_i = vecs[i].ordy;
      carry_i = vecs[i].cy; zero_i = vecs[i].zr;
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(dut_vec()),
            32'({vecs[i].st, vecs[i].pc, vecs[i].req, vecs[i].we, vecs[i].addr,
                 vecs[i].awe, vecs[i].sel, vecs[i].flw, vecs[i].ird,
                 vecs[i].ovl, vecs[i].bmem}));
      @(posedge clk);
    end

    // Taken BRC targeting its own address keeps refetching address 0.
    #1; rst_i = 1'b1; mem_ack_i = 1'b0;
    @(posedge clk);
    #1; rst_i = 1'b0; instr_i = 8'h50; mem_ack_i = 1'b1; carry_i = 1'b1; zero_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("selfloop%0d", k), 32'({state_o, pc_o, mem_addr_o}), 32'({3'd0, 4'd0, 4'd0}));
      repeat (3) @(posedge clk);
    end

    // Randomized run against the model.
    #1; rst_i = 1'b1; mem_ack_i = 1'b0;
    @(posedge clk);
    m_st = 0; m_pc = 4'd0; m_ir = 8'd0;
    for (int c = 0; c < 3000; c++) begin
      #1;
      rst_i       = ($urandom_range(0, 59) == 0);
      instr_i     = 8'($urandom);
      mem_ack_i   = ($urandom_range(0, 9) < 6);
      inp_valid_i = ($urandom_range(0, 9) < 5);
      out_ready_i = ($urandom_range(0, 9) < 5);
      carry_i     = 1'($urandom);
      zero_i      = 1'($urandom);
      @(negedge clk);
      check($sformatf("rand%0d_outs", c), 32'(dut_vec()), 32'(model_vec()));
      check($sformatf("rand%0d_ir", c), 32'({ir_o, alu_op_o}), 32'({m_ir, m_ir[6:4]}));
      @(posedge clk);
      model_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
